// File: rtl/two_phase_pkg.sv
// two_phase_pkg: shared state encoding and error-flag indices for the two-phase clock monitor
package two_phase_pkg;
    typedef enum logic [1:0] {HUNT, EXP_P2, EXP_P1} state_e;
    localparam int ERR_OVERLAP = 0;
    localparam int ERR_ORDER   = 1;
    localparam int ERR_TIMEOUT = 2;
    localparam int ERR_W       = 3;
endpackage

// File: rtl/phase_sync_edge.sv
// phase_sync_edge: multi-flop synchronizer for one phase input plus a registered one-cycle rise strobe
module phase_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic s_o,
    output logic rise_o
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic prev_q, rise_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            prev_q <= sync_q[SYNC_STAGES-1];
            rise_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
        end
    end
    assign s_o    = sync_q[SYNC_STAGES-1];
    assign rise_o = rise_q;
endmodule

// File: rtl/two_phase_monitor.sv
// two_phase_monitor: checks non-overlap and alternation of phi1/phi2, measures the phi1 period
// and reports lock plus sticky overlap/order/timeout errors.
module two_phase_monitor
    import two_phase_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8,
    parameter int LOCK_COUNT  = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             phi1_in,
    input  logic             phi2_in,
    input  logic             err_clr,
    output logic             locked,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             err_overlap,
    output logic             err_order,
    output logic             err_timeout
);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [3:0]       LOCK_N    = 4'(LOCK_COUNT);

    logic p1_s, p2_s, p1_rise, p2_rise, ov, any_rise;
    state_e state_q, state_d;
    logic [CNT_W-1:0] period_cnt_q, period_cnt_d, idle_q, idle_d, period_q, period_d;
    logic [3:0] good_q, good_d;
    logic locked_q, locked_d, pv_q, pv_d;
    logic [ERR_W-1:0] err_q, err_d, err_set;

    phase_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_p1 (
        .clk(clk), .rst(rst), .d_i(phi1_in), .s_o(p1_s), .rise_o(p1_rise)
    );
    phase_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_p2 (
        .clk(clk), .rst(rst), .d_i(phi2_in), .s_o(p2_s), .rise_o(p2_rise)
    );

    // simultaneous rise strobes are treated exactly like a level overlap
    assign ov       = (p1_s & p2_s) | (p1_rise & p2_rise);
    assign any_rise = p1_rise | p2_rise;

    always_comb begin
        state_d  = state_q;
        err_set  = '0;
        pv_d     = 1'b0;
        period_d = period_q;
        good_d   = good_q;
        if (ov) begin
            err_set[ERR_OVERLAP] = 1'b1;
            state_d = HUNT;
        end else if (state_q == HUNT) begin
            state_d = p1_rise ? EXP_P2 : HUNT;
        end else if (state_q == EXP_P2 ? p1_rise : p2_rise) begin
            err_set[ERR_ORDER] = 1'b1;
            state_d = HUNT;
        end else if (any_rise) begin
            state_d = p1_rise ? EXP_P2 : EXP_P1;
            if (p1_rise) begin
                pv_d     = 1'b1;
                period_d = (period_cnt_q == CNT_MAX) ? CNT_MAX : period_cnt_q + 1'b1;
                good_d   = (good_q == LOCK_N) ? LOCK_N : good_q + 4'd1;
            end
        end else if (idle_q == IDLE_LAST) begin
            err_set[ERR_TIMEOUT] = 1'b1;
            state_d = HUNT;
        end
        if (state_d == HUNT) good_d = '0;
        locked_d     = (good_d == LOCK_N);
        idle_d       = (state_d == HUNT || any_rise) ? '0 : idle_q + 1'b1;
        period_cnt_d = p1_rise ? '0 : (period_cnt_q == CNT_MAX) ? CNT_MAX : period_cnt_q + 1'b1;
        err_d        = (err_clr ? '0 : err_q) | err_set;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= HUNT;
            period_cnt_q <= '0;
            idle_q       <= '0;
            period_q     <= '0;
            good_q       <= '0;
            locked_q     <= 1'b0;
            pv_q         <= 1'b0;
            err_q        <= '0;
        end else begin
            state_q      <= state_d;
            period_cnt_q <= period_cnt_d;
            idle_q       <= idle_d;
            period_q     <= period_d;
            good_q       <= good_d;
            locked_q     <= locked_d;
            pv_q         <= pv_d;
            err_q        <= err_d;
        end
    end

    assign locked       = locked_q;
    assign period       = period_q;
    assign period_valid = pv_q;
    assign err_overlap  = err_q[ERR_OVERLAP];
    assign err_order    = err_q[ERR_ORDER];
    assign err_timeout  = err_q[ERR_TIMEOUT];
endmodule

// File: tb/tb_two_phase_monitor.sv
// tb_two_phase_monitor: directed vector table for the prescaler pattern plus hand-timed corner sequences
module tb_two_phase_monitor;
    logic clk = 1'b0;
    logic rst, phi1_in, phi2_in, err_clr;
    logic locked, period_valid, err_overlap, err_order, err_timeout;
    logic [7:0] period;
    int n_chk = 0, n_fail = 0, cyc = 0, pv_seen = 0;

    typedef struct {
        logic       p1, p2;
        logic       lk, pv;
        logic [7:0] per;
    } vec_t;
    vec_t tbl[32];

    two_phase_monitor dut (
        .clk(clk), .rst(rst), .phi1_in(phi1_in), .phi2_in(phi2_in), .err_clr(err_clr),
        .locked(locked), .period(period), .period_valid(period_valid),
        .err_overlap(err_overlap), .err_order(err_order), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic step(input logic a, input logic b, input logic c);
        phi1_in = a;
        phi2_in = b;
        err_clr = c;
        @(posedge clk);
        #1;
        cyc++;
        if (period_valid) pv_seen++;
    endtask

    task automatic pat(input int k);
        repeat (k) step(cyc % 4 == 1, cyc % 4 == 3, 1'b0);
    endtask

    task automatic check_errs(input string name, input logic [2:0] exp);
        check(name, {err_timeout, err_order, err_overlap}, exp);
    endtask

    initial begin
        // 4-clk prescaler: phi1 at phase 1, phi2 at phase 3; outputs lag the inputs by 4 clks
        for (int i = 0; i < 32; i++) begin
            tbl[i].p1  = (i % 4 == 1);
            tbl[i].p2  = (i % 4 == 3);
            tbl[i].lk  = (i >= 20);
            tbl[i].pv  = (i >= 8) && (i % 4 == 0);
            tbl[i].per = (i >= 8) ? 8'd4 : 8'd0;
        end
        rst = 1'b1; phi1_in = 1'b0; phi2_in = 1'b0; err_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_locked", locked, 0);
        check("reset_period", period, 0);
        check("reset_pv", period_valid, 0);
        check_errs("reset_errs", 3'b000);
        rst = 1'b0;
        cyc = 0;

        for (int i = 0; i < 32; i++) begin
            step(tbl[i].p1, tbl[i].p2, 1'b0);
            check("t1_locked", locked, tbl[i].lk);
            check("t1_pv", period_valid, tbl[i].pv);
            check("t1_period", period, tbl[i].per);
            check_errs("t1_errs", 3'b000);
        end

        // overlap while locked: both phases high during row 34
        pat(2);
        step(1'b1, 1'b1, 1'b0);
        pat(1);
        check("t2_ovl_before", err_overlap, 0);
        check("t2_lock_before", locked, 1);
        pat(1);
        check("t2_ovl_set", err_overlap, 1);
        check("t2_lock_drop", locked, 0);
        check("t2_order_clean", err_order, 0);
        pat(19);
        check("t2_relock_early", locked, 0);
        pat(1);
        check("t2_relock", locked, 1);
        check("t2_ovl_sticky", err_overlap, 1);
        step(cyc % 4 == 1, cyc % 4 == 3, 1'b1);
        check("t2_ovl_clr", err_overlap, 0);
        check("t2_lock_kept", locked, 1);

        // missing phi2 pulse at row 59
        pat(1);
        step(1'b0, 1'b0, 1'b0);
        pat(4);
        check("t3_order_before", err_order, 0);
        check("t3_lock_before", locked, 1);
        pat(1);
        check("t3_order_set", err_order, 1);
        check("t3_lock_drop", locked, 0);

        // relock, then stop both phases; last rise strobe is consumed at the edge ending cycle 88
        pat(21);
        check("t4_relock", locked, 1);
        repeat (257) step(1'b0, 1'b0, 1'b0);
        check("t4_to_before", err_timeout, 0);
        check("t4_lock_before", locked, 1);
        step(1'b0, 1'b0, 1'b0);
        check("t4_to_set", err_timeout, 1);
        check("t4_lock_drop", locked, 0);
        step(1'b0, 1'b0, 1'b1);
        check_errs("t4_clr", 3'b000);
        repeat (300) step(1'b0, 1'b0, 1'b0);
        check_errs("t4_hunt_idle", 3'b000);
        check("t4_period_kept", period, 4);

        // 300-clk phi1 period saturates the 8-bit measurement
        pv_seen = 0;
        for (int p = 0; p < 5; p++) begin
            step(1'b1, 1'b0, 1'b0);
            repeat (149) step(1'b0, 1'b0, 1'b0);
            step(1'b0, 1'b1, 1'b0);
            repeat (149) step(1'b0, 1'b0, 1'b0);
        end
        check("t5_period_sat", period, 255);
        check("t5_pv_count", pv_seen, 4);
        check("t5_locked", locked, 1);
        check_errs("t5_errs", 3'b000);

        // asynchronous reset mid-cycle
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("t6_rst_locked", locked, 0);
        check("t6_rst_period", period, 0);
        check("t6_rst_pv", period_valid, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("t6_hunt_ovl", err_overlap, 1);
        check("t6_hunt_unlocked", locked, 0);
        repeat (2) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        check("t6_ovl_clr", err_overlap, 0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        check("t6_set_wins", err_overlap, 1);
        repeat (2) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        check("t6_ovl_clr2", err_overlap, 0);
        check_errs("t6_errs_final", 3'b000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
